// File: rtl/axi_arbiter_r.sv
// Round-robin AXI read-channel arbiter for four masters; holds the grant from AR until the last R beat.
// Optional forced-release watchdog on stalled R data: define AXI_ARB_R_TIMEOUT_EN.
module axi_arbiter_r #(
    parameter int unsigned FIRST_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       m0_ARVALID,
    input  logic       m1_ARVALID,
    input  logic       m2_ARVALID,
    input  logic       m3_ARVALID,
    input  logic       ARREADY,
    input  logic       RVALID,
    input  logic       RREADY,
    input  logic       RLAST,
    output logic       m0_rgrnt,
    output logic       m1_rgrnt,
    output logic       m2_rgrnt,
    output logic       m3_rgrnt,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned NUM_M  = 4;
    localparam int unsigned ID_W   = 2;
    localparam logic [ID_W-1:0] RST_LAST = ID_W'((FIRST_PRIO + 3) % NUM_M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;

    logic [NUM_M-1:0]  arvalid;
    logic [ID_W-1:0]   pick_base;
    logic [ID_W:0]     pick_res;
    logic              r_hs;
    logic              r_done;

    assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign r_hs    = RVALID && RREADY;
    assign r_done  = r_hs && RLAST;

    // First requester after base, wrapping; MSB of result flags "found".
    function automatic logic [ID_W:0] pick(input logic [NUM_M-1:0] req,
                                           input logic [ID_W-1:0]  base);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int i = NUM_M; i >= 1; i--) begin
            idx = base + ID_W'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // In DATA the completing master becomes the new round-robin base in the same edge.
    assign pick_base = (state_q == DATA) ? id_q : last_q;
    assign pick_res  = pick(arvalid, pick_base);

`ifdef AXI_ARB_R_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        last_d  = last_q;
        busy_d  = busy_q;
        terr_d  = 1'b0;
`ifdef AXI_ARB_R_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_res[ID_W]) begin
                    grant_d = NUM_M'(1) << pick_res[ID_W-1:0];
                    id_d    = pick_res[ID_W-1:0];
                    busy_d  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (arvalid[id_q] && ARREADY) begin
                    state_d = DATA;
`ifdef AXI_ARB_R_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            DATA: begin
                if (r_done) begin
                    last_d = id_q;
                    if (pick_res[ID_W]) begin
                        grant_d = NUM_M'(1) << pick_res[ID_W-1:0];
                        id_d    = pick_res[ID_W-1:0];
                        state_d = ADDR;
                    end else begin
                        grant_d = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
`ifdef AXI_ARB_R_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    last_d  = id_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else if (r_hs) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            last_q  <= RST_LAST;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
`ifdef AXI_ARB_R_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
`ifdef AXI_ARB_R_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m0_rgrnt    = grant_q[0];
    assign m1_rgrnt    = grant_q[1];
    assign m2_rgrnt    = grant_q[2];
    assign m3_rgrnt    = grant_q[3];
    assign grant_id    = id_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule
